// File: rtl/frame_ring_buffer.sv
// Ring of NUM_BANKS frame buffers between camera writer and pixel consumer.
// Read data is registered, so it appears one cycle after issue. The consumer can stall reads with pause.
module frame_ring_buffer #(
  parameter  int DATA_W       = 8,
  parameter  int FRAME_PIXELS = 64,
  parameter  int NUM_BANKS    = 2,
  localparam int ADDR_W       = $clog2(FRAME_PIXELS),
  localparam int BANK_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int CNT_W        = $clog2(NUM_BANKS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              frame_done,
  input  logic              rd_enable,
  input  logic              pause,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_done,
  output logic [CNT_W-1:0]  frames_stored
);

  typedef enum logic {R_IDLE, R_STREAM} rd_state_t;

  logic [DATA_W-1:0] r_mem [NUM_BANKS][FRAME_PIXELS];

  logic [BANK_W-1:0] r_wb, r_rb;
  logic [ADDR_W-1:0] r_wp, r_rp;
  logic [CNT_W-1:0]  r_cnt;
  rd_state_t         r_state;
  logic              r_frame_done, r_rd_valid, r_rd_done;
  logic [DATA_W-1:0] r_rd_data;

  logic              w_wr_ready, w_wr_acc, w_wr_last;
  logic              w_issue, w_rd_last;
  logic [CNT_W-1:0]  w_cnt_nxt;

  assign w_wr_ready = (r_cnt != CNT_W'(NUM_BANKS));
  assign w_wr_acc   = wr_en && w_wr_ready;
  assign w_wr_last  = w_wr_acc && (r_wp == ADDR_W'(FRAME_PIXELS - 1));
  assign w_issue    = (r_state == R_STREAM) && rd_enable && !pause;
  assign w_rd_last  = w_issue && (r_rp == ADDR_W'(FRAME_PIXELS - 1));

  // Completing and freeing a bank in the same cycle leaves the count unchanged.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_wr_last && !w_rd_last)
      w_cnt_nxt = r_cnt + CNT_W'(1);
    else if (!w_wr_last && w_rd_last)
      w_cnt_nxt = r_cnt - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc && !rst && !clear)
      r_mem[r_wb][r_wp] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_wb         <= '0;
      r_wp         <= '0;
      r_rb         <= '0;
      r_rp         <= '0;
      r_cnt        <= '0;
      r_state      <= R_IDLE;
      r_frame_done <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_done    <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_frame_done <= w_wr_last;
      r_rd_valid   <= w_issue;
      r_rd_done    <= w_rd_last;

      if (w_wr_acc) begin
        if (w_wr_last) begin
          r_wp <= '0;
          r_wb <= (r_wb == BANK_W'(NUM_BANKS - 1)) ? '0 : r_wb + BANK_W'(1);
        end else begin
          r_wp <= r_wp + ADDR_W'(1);
        end
      end

      if (w_issue) begin
        r_rd_data <= r_mem[r_rb][r_rp];
        if (w_rd_last) begin
          r_rp <= '0;
          r_rb <= (r_rb == BANK_W'(NUM_BANKS - 1)) ? '0 : r_rb + BANK_W'(1);
        end else begin
          r_rp <= r_rp + ADDR_W'(1);
        end
      end

      // Stay streaming across a frame boundary when another full bank is ready.
      case (r_state)
        R_IDLE:   if (rd_enable && r_cnt != '0) r_state <= R_STREAM;
        R_STREAM: if (w_rd_last && !(rd_enable && w_cnt_nxt != '0)) r_state <= R_IDLE;
        default:  r_state <= R_IDLE;
      endcase
    end
  end

  assign wr_ready      = w_wr_ready;
  assign frame_done    = r_frame_done;
  assign rd_data       = r_rd_data;
  assign rd_valid      = r_rd_valid;
  assign rd_done       = r_rd_done;
  assign frames_stored = r_cnt;

endmodule
